// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register indices and forwarding tracker entries.
package cpu_types_pkg;

  // Architectural register index width used across the datapath.
  localparam int CPU_REG_W = 5;

  // Width of the stored "ready stage" field; wide enough for deep pipelines.
  localparam int FWD_RDY_W = 4;

  typedef logic [CPU_REG_W-1:0] regbits_t;
  typedef logic [FWD_RDY_W-1:0] fwdrdy_t;

  // One in-flight register write: is it real, where it goes, and the first
  // post-decode stage whose output carries its result.
  typedef struct packed {
    logic     valid;
    regbits_t dst;
    fwdrdy_t  rdy;
  } fwd_entry_t;

  // Result available at the EX output (ALU, LUI, JAL).
  localparam fwdrdy_t FWD_RDY_ALU  = 4'd0;
  // Result available one stage later (load data out of MEM).
  localparam fwdrdy_t FWD_RDY_LOAD = 4'd1;

  // Empty slot inserted for stalls and flushes.
  localparam fwd_entry_t FWD_BUBBLE = '{valid: 1'b0, dst: 5'd0, rdy: 4'd0};

  // A producer sitting in stage `stage` has its value once it reached rdy.
  function automatic logic fwd_is_ready(fwd_entry_t e, int stage);
    return (stage >= int'(e.rdy));
  endfunction

  // $0 is hard-wired, so it never matches even when an entry targets it.
  function automatic logic fwd_matches(fwd_entry_t e, regbits_t src);
    return e.valid && (src != 5'd0) && (e.dst == src);
  endfunction

endpackage

// File: rtl/fwd_tracker.sv
// Shift register of in-flight register writes, one slot per post-decode
// stage, with bubble insertion for stalled or squashed issues.
module fwd_tracker
  import cpu_types_pkg::*;
#(
  parameter int NSTAGE = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic                    flush,
  input  logic                    stall,
  input  logic                    issue_wr,
  input  regbits_t                issue_dst,
  input  fwdrdy_t                 issue_rdy,
  output fwd_entry_t [NSTAGE-1:0] entry
);

  fwd_entry_t [NSTAGE-1:0] entry_q;
  fwd_entry_t [NSTAGE-1:0] entry_d;

  // Next tracker contents: shift on advance, squash the EX slot on flush.
  always_comb begin
    entry_d = entry_q;
    if (adv) begin
      for (int i = NSTAGE - 1; i > 0; i--) begin
        entry_d[i] = entry_q[i-1];
      end
      // The instruction leaving decode into EX is squashed by a flush.
      if (flush) begin
        entry_d[1] = FWD_BUBBLE;
      end else begin
        entry_d[1] = entry_q[0];
      end
      // A stalled or flushed decode instruction enters as a bubble.
      entry_d[0].valid = issue_wr & ~stall & ~flush;
      entry_d[0].dst   = issue_dst;
      entry_d[0].rdy   = issue_rdy;
    end else if (flush) begin
      entry_d[0].valid = 1'b0;
    end else begin
      entry_d = entry_q;
    end
  end

  // Tracker state register; reset empties every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard scoreboard: per-operand youngest-producer lookup
// over the tracked stages, load-use stall generation and a stall counter.
module fwd_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NPORT  = 3,
  parameter int NSTAGE = 3,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       adv,
  input  logic                       flush,
  input  logic                       issue_wr,
  input  logic [REG_W-1:0]           issue_dst,
  input  logic [$clog2(NSTAGE)-1:0]  issue_rdy,
  input  logic [NPORT*REG_W-1:0]     src_reg,
  input  logic [NSTAGE*DATA_W-1:0]   stage_wdat,
  output logic [NPORT-1:0]           fwd_hit,
  output logic [NPORT*DATA_W-1:0]    fwd_dat,
  output logic                       stall,
  output logic [CNT_W-1:0]           stall_cnt
);

  fwd_entry_t [NSTAGE-1:0] entry;
  logic [NPORT-1:0]        port_vote;
  logic [CNT_W-1:0]        stall_cnt_q;
  logic [CNT_W-1:0]        stall_cnt_d;

  fwd_tracker #(
    .NSTAGE   (NSTAGE)
  ) u_tracker (
    .clk       (CLK),
    .rst_n     (nRST),
    .adv       (adv),
    .flush     (flush),
    .stall     (stall),
    .issue_wr  (issue_wr),
    .issue_dst (regbits_t'(issue_dst)),
    .issue_rdy (fwdrdy_t'(issue_rdy)),
    .entry     (entry)
  );

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    regbits_t          src_s;
    logic              found_s;
    logic              hit_s;
    logic              vote_s;
    logic [DATA_W-1:0] dat_s;

    assign src_s = regbits_t'(src_reg[p*REG_W +: REG_W]);

    // Youngest matching producer decides: forward if ready, else vote stall.
    always_comb begin
      found_s = 1'b0;
      hit_s   = 1'b0;
      vote_s  = 1'b0;
      dat_s   = '0;
      for (int i = 0; i < NSTAGE; i++) begin
        if (!found_s && fwd_matches(entry[i], src_s)) begin
          found_s = 1'b1;
          if (fwd_is_ready(entry[i], i)) begin
            hit_s = 1'b1;
            dat_s = stage_wdat[i*DATA_W +: DATA_W];
          end else begin
            vote_s = 1'b1;
          end
        end else begin
          found_s = found_s;
        end
      end
    end

    assign fwd_hit[p]                  = hit_s;
    assign fwd_dat[p*DATA_W +: DATA_W] = dat_s;
    assign port_vote[p]                = vote_s;
  end

  // A flush kills the waiting consumer, so it must not hold decode.
  assign stall = (|port_vote) & ~flush;

  // Saturating count of stalled cycles.
  always_comb begin
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus random
// traffic, all compared against a queue-based model of in-flight writes.
module tb_fwd_scoreboard;

  localparam int NPORT  = 3;
  localparam int NSTAGE = 3;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic                      CLK = 1'b0;
  logic                      nRST;
  logic                      adv;
  logic                      flush;
  logic                      issue_wr;
  logic [REG_W-1:0]          issue_dst;
  logic [1:0]                issue_rdy;
  logic [NPORT*REG_W-1:0]    src_reg;
  logic [NSTAGE*DATA_W-1:0]  stage_wdat;
  logic [NPORT-1:0]          fwd_hit;
  logic [NPORT*DATA_W-1:0]   fwd_dat;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fwd_scoreboard #(
    .NPORT (NPORT), .NSTAGE (NSTAGE), .REG_W (REG_W),
    .DATA_W (DATA_W), .CNT_W (CNT_W)
  ) dut (
    .CLK (CLK), .nRST (nRST), .adv (adv), .flush (flush),
    .issue_wr (issue_wr), .issue_dst (issue_dst), .issue_rdy (issue_rdy),
    .src_reg (src_reg), .stage_wdat (stage_wdat),
    .fwd_hit (fwd_hit), .fwd_dat (fwd_dat), .stall (stall),
    .stall_cnt (stall_cnt)
  );

  // Model: list of in-flight writes, youngest first; each has been in flight
  // for (list position) cycles and its value exists once that reaches rdy.
  typedef struct {
    bit v;
    int dst;
    int rdy;
  } ment_t;

  ment_t           mq[$];
  int              mcnt;
  bit              exp_stall;
  bit [NPORT-1:0]  exp_hit;
  logic [NPORT*DATA_W-1:0] exp_dat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    ment_t e;
    e.v = 1'b0; e.dst = 0; e.rdy = 0;
    mq.delete();
    for (int i = 0; i < NSTAGE; i++) mq.push_back(e);
    mcnt = 0;
  endfunction

  function automatic void mdl_lookup();
    bit vote;
    vote = 1'b0;
    exp_hit = '0;
    exp_dat = '0;
    for (int p = 0; p < NPORT; p++) begin
      int s;
      bit done;
      s = int'(src_reg[p*REG_W +: REG_W]);
      done = 1'b0;
      for (int age = 0; age < NSTAGE; age++) begin
        if (!done && s != 0 && mq[age].v && mq[age].dst == s) begin
          done = 1'b1;
          if (age >= mq[age].rdy) begin
            exp_hit[p] = 1'b1;
            exp_dat[p*DATA_W +: DATA_W] = stage_wdat[age*DATA_W +: DATA_W];
          end else begin
            vote = 1'b1;
          end
        end
      end
    end
    exp_stall = vote && !flush;
  endfunction

  function automatic void mdl_advance();
    ment_t n;
    if (exp_stall && mcnt != 65535) mcnt++;
    if (adv) begin
      n.v   = issue_wr && !exp_stall && !flush;
      n.dst = int'(issue_dst);
      n.rdy = int'(issue_rdy);
      mq.push_front(n);
      void'(mq.pop_back());
      if (flush) mq[1].v = 1'b0;
    end else if (flush) begin
      mq[0].v = 1'b0;
    end
  endfunction

  task automatic settle();
    @(negedge CLK);
    mdl_lookup();
    for (int p = 0; p < NPORT; p++) begin
      chk($sformatf("hit%0d", p), 32'(fwd_hit[p]), 32'(exp_hit[p]));
      chk($sformatf("dat%0d", p), fwd_dat[p*DATA_W +: DATA_W], exp_dat[p*DATA_W +: DATA_W]);
    end
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("stall_cnt", 32'(stall_cnt), mcnt);
  endtask

  task automatic advance();
    @(posedge CLK);
    mdl_advance();
    #1;
  endtask

  task automatic set_src(input int a, input int b, input int c);
    src_reg = {REG_W'(c), REG_W'(b), REG_W'(a)};
  endtask

  task automatic issue(input bit wr, input int dst, input int rdy);
    issue_wr  = wr;
    issue_dst = REG_W'(dst);
    issue_rdy = 2'(rdy);
  endtask

  initial begin
    nRST = 1'b0; adv = 1'b1; flush = 1'b0;
    issue(1'b0, 0, 0);
    set_src(0, 0, 0);
    stage_wdat = '0;
    mdl_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_hit", 32'(fwd_hit), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    nRST = 1'b1;

    // ALU producer then dependent consumer
    issue(1'b1, 3, 0); settle(); advance();
    issue(1'b0, 0, 0); set_src(3, 0, 0);
    stage_wdat = {32'h0, 32'h0, 32'h0000_0010};
    settle();
    chk("alu_hit", 32'(fwd_hit), 32'd1);
    chk("alu_dat", fwd_dat[31:0], 32'h10);
    chk("alu_stall", 32'(stall), 32'd0);
    advance();

    // Load-use: one stall, then forward from stage 1
    issue(1'b1, 5, 1); set_src(0, 0, 0); settle(); advance();
    issue(1'b1, 6, 0); set_src(0, 5, 0);
    settle();
    chk("lu_stall", 32'(stall), 32'd1);
    advance();
    set_src(0, 5, 6);
    stage_wdat = {32'h0, 32'hDEAD_BEEF, 32'h0};
    settle();
    chk("lu_stall2", 32'(stall), 32'd0);
    chk("lu_hit", 32'(fwd_hit), 32'b010);
    chk("lu_dat", fwd_dat[63:32], 32'hDEAD_BEEF);
    advance();

    // Youngest producer wins
    set_src(0, 0, 0);
    issue(1'b1, 7, 0); settle(); advance();
    issue(1'b1, 9, 0); settle(); advance();
    issue(1'b1, 7, 0); settle(); advance();
    issue(1'b0, 0, 0); set_src(7, 0, 0);
    stage_wdat = {32'h2, 32'h55, 32'h1};
    settle();
    chk("young_dat", fwd_dat[31:0], 32'h1);
    advance();

    // $0 never matches, even against a not-ready write to $0
    set_src(0, 0, 0);
    issue(1'b1, 0, 1); settle(); advance();
    issue(1'b0, 0, 0);
    settle();
    chk("r0_hit", 32'(fwd_hit), 32'd0);
    chk("r0_stall", 32'(stall), 32'd0);
    advance();

    // Load-use held by adv=0 for 3 cycles
    nRST = 1'b0; #2; nRST = 1'b1;
    mdl_reset();
    issue(1'b1, 4, 1); settle(); advance();
    issue(1'b1, 8, 0); set_src(4, 0, 0); adv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("hold_stall", 32'(stall), 32'd1);
      advance();
    end
    adv = 1'b1;
    settle();
    chk("hold_stall4", 32'(stall), 32'd1);
    advance();
    settle();
    chk("hold_cnt", 32'(stall_cnt), 32'd4);
    chk("hold_after", 32'(stall), 32'd0);
    advance();

    // Flush during a load-use stall clears the EX producer in place
    issue(1'b1, 4, 1); set_src(0, 0, 0); settle(); advance();
    issue(1'b1, 8, 0); set_src(4, 0, 0); flush = 1'b1; adv = 1'b0;
    settle();
    chk("flush_stall", 32'(stall), 32'd0);
    advance();
    flush = 1'b0; adv = 1'b1; issue(1'b0, 0, 0);
    settle();
    chk("flush_hit", 32'(fwd_hit), 32'd0);
    chk("flush_stall2", 32'(stall), 32'd0);
    advance();

    // Asynchronous reset with three valid producers in flight
    set_src(0, 0, 0);
    issue(1'b1, 1, 0); settle(); advance();
    issue(1'b1, 2, 0); settle(); advance();
    issue(1'b1, 3, 0); settle(); advance();
    issue(1'b0, 0, 0); set_src(1, 2, 3);
    stage_wdat = {32'hC, 32'hB, 32'hA};
    settle();
    chk("pre_rst_hit", 32'(fwd_hit), 32'b111);
    #2 nRST = 1'b0;
    #1;
    chk("arst_hit", 32'(fwd_hit), 32'd0);
    chk("arst_dat0", fwd_dat[31:0], 32'd0);
    chk("arst_dat2", fwd_dat[95:64], 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_cnt", 32'(stall_cnt), 32'd0);
    mdl_reset();
    mdl_lookup();
    #1 nRST = 1'b1;
    advance();
    settle();
    chk("post_rst_hit", 32'(fwd_hit), 32'd0);
    advance();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      adv   = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 9) == 0);
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
      set_src(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      stage_wdat = {$urandom, $urandom, $urandom};
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
